// File: rtl/blake2_block_ctrl.sv
// rtl/blake2_block_ctrl.sv - blake2 message packer and block sequencer
// Packs a W-bit word stream into zero-padded 16-word blocks, issues them to the core, returns the digest.
module blake2_block_ctrl #(
  parameter int          W  = 64,
  parameter logic [7:0]  NN = 8'd64,
  localparam int         BW = $clog2(W/8) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        kk_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  input  logic [W-1:0]      data_i,
  input  logic              data_last_i,
  input  logic [BW-1:0]     data_bytes_i,
  output logic              core_valid_o,
  output logic [16*W-1:0]   core_d_o,
  output logic              core_first_o,
  output logic              core_last_o,
  output logic [63:0]       core_ll_o,
  output logic [7:0]        core_kk_o,
  output logic [7:0]        core_nn_o,
  input  logic              core_done_i,
  input  logic [8*W-1:0]    core_h_i,
  output logic              hash_valid_o,
  output logic [8*W-1:0]    hash_o
);
  localparam int WB = W / 8;

  typedef enum logic [1:0] {IDLE, FILL, ISSUE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [3:0]         word_idx_q, word_idx_d;
  logic [15:0][W-1:0] buf_q, buf_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic [63:0]        ll_q, ll_d;
  logic [7:0]         kk_q, kk_d;
  logic [8*W-1:0]     hash_q, hash_d;
  logic               hash_valid_q, hash_valid_d;
  logic [W-1:0]       word_masked;
  logic [63:0]        ll_inc;
  logic               accept;

  // Ready is held low while reset is asserted so nothing looks acceptable during reset.
  assign data_ready_o = ~reset & ((state_q == IDLE) | (state_q == FILL));
  assign accept       = data_valid_i & data_ready_o;
  assign ll_inc       = data_last_i ? 64'(data_bytes_i) : 64'(WB);

  always_comb begin
    word_masked = data_i;
    if (data_last_i) begin
      for (int k = 0; k < WB; k++) begin
        if (k >= int'(data_bytes_i)) word_masked[8*k +: 8] = 8'h00;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    buf_d        = buf_q;
    first_d      = first_q;
    last_d       = last_q;
    ll_d         = ll_q;
    kk_d         = kk_q;
    hash_d       = hash_q;
    hash_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          buf_d      = '0;
          buf_d[0]   = word_masked;
          first_d    = 1'b1;
          last_d     = data_last_i;
          kk_d       = kk_i;
          ll_d       = ll_inc;
          if (data_last_i) begin
            word_idx_d = 4'd0;
            state_d    = ISSUE;
          end else begin
            word_idx_d = 4'd1;
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        if (accept) begin
          buf_d[word_idx_q] = word_masked;
          last_d            = data_last_i;
          ll_d              = ll_q + ll_inc;
          word_idx_d        = word_idx_q + 4'd1;
          if (data_last_i || word_idx_q == 4'd15) state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (core_done_i) begin
          buf_d      = '0;
          word_idx_d = 4'd0;
          if (last_q) begin
            hash_d       = core_h_i;
            hash_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            first_d = 1'b0;
            state_d = FILL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      word_idx_q   <= 4'd0;
      buf_q        <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      ll_q         <= 64'd0;
      kk_q         <= 8'd0;
      hash_q       <= '0;
      hash_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      buf_q        <= buf_d;
      first_q      <= first_d;
      last_q       <= last_d;
      ll_q         <= ll_d;
      kk_q         <= kk_d;
      hash_q       <= hash_d;
      hash_valid_q <= hash_valid_d;
    end
  end

  // The block fields come straight from registers that only change outside ISSUE/WAIT.
  assign core_valid_o = (state_q == ISSUE);
  assign core_d_o     = buf_q;
  assign core_first_o = first_q;
  assign core_last_o  = last_q;
  assign core_ll_o    = ll_q;
  assign core_kk_o    = kk_q;
  assign core_nn_o    = NN;
  assign hash_valid_o = hash_valid_q;
  assign hash_o       = hash_q;

endmodule

// File: tb/tb_blake2_block_ctrl.sv
// tb/tb_blake2_block_ctrl.sv - randomized bench for blake2_block_ctrl
// Reference derives each block from the message byte array: block b is bytes [128b,128b+128) zero padded.
module tb_blake2_block_ctrl;
  localparam int W  = 64;
  localparam int WB = W / 8;
  localparam int BW = $clog2(WB) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        kk_i;
  logic              data_valid_i;
  logic              data_ready_o;
  logic [W-1:0]      data_i;
  logic              data_last_i;
  logic [BW-1:0]     data_bytes_i;
  logic              core_valid_o;
  logic [16*W-1:0]   core_d_o;
  logic              core_first_o;
  logic              core_last_o;
  logic [63:0]       core_ll_o;
  logic [7:0]        core_kk_o;
  logic [7:0]        core_nn_o;
  logic              core_done_i;
  logic [8*W-1:0]    core_h_i;
  logic              hash_valid_o;
  logic [8*W-1:0]    hash_o;

  blake2_block_ctrl #(.W(W), .NN(8'd64)) dut (
    .clk(clk), .reset(reset), .kk_i(kk_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
    .data_last_i(data_last_i), .data_bytes_i(data_bytes_i),
    .core_valid_o(core_valid_o), .core_d_o(core_d_o), .core_first_o(core_first_o),
    .core_last_o(core_last_o), .core_ll_o(core_ll_o), .core_kk_o(core_kk_o),
    .core_nn_o(core_nn_o), .core_done_i(core_done_i), .core_h_i(core_h_i),
    .hash_valid_o(hash_valid_o), .hash_o(hash_o)
  );

  always #5 clk = ~clk;

  int        checks = 0;
  int        errors = 0;
  int        issue_cnt = 0;
  byte       msg[$];
  logic [7:0] msg_kk;

  always @(posedge clk) if (!reset && core_valid_o) issue_cnt <= issue_cnt + 1;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16*W-1:0] exp_block(input int b);
    logic [16*W-1:0] r;
    r = '0;
    for (int i = 0; i < 128; i++)
      if (128*b + i < msg.size()) r[8*i +: 8] = msg[128*b + i];
    return r;
  endfunction

  function automatic int num_words();
    return (msg.size() == 0) ? 1 : (msg.size() + WB - 1) / WB;
  endfunction

  task automatic drive(input bit gaps);
    int n;
    int cyc;
    bit spur;
    n = num_words();
    @(negedge clk);
    for (int w = 0; w < n; w++) begin
      spur = 1'b0;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          data_valid_i = 1'b0;
          if (w % 16 != 0 && $urandom_range(0, 1) == 1) begin
            core_done_i = 1'b1;
            spur = 1'b1;
          end
          @(negedge clk);
          if (spur) begin
            core_done_i = 1'b0;
            spur = 1'b0;
          end
        end
      end
      data_valid_i = 1'b1;
      data_last_i  = (w == n - 1);
      kk_i         = (w == 0) ? msg_kk : 8'($urandom);
      for (int k = 0; k < WB; k++)
        data_i[8*k +: 8] = (WB*w + k < msg.size()) ? msg[WB*w + k] : 8'($urandom);
      data_bytes_i = (w == n - 1) ? BW'(msg.size() - WB*(n-1)) : BW'($urandom_range(0, WB));
      cyc = 0;
      while (!data_ready_o && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      if (cyc >= 2000) check("accept_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
      if (w % 16 == 15 || w == n - 1) check("issue_latency", 512'(core_valid_o), 1);
    end
    data_valid_i = 1'b0;
    data_last_i  = 1'b0;
  endtask

  task automatic respond(input int nblk);
    int cyc;
    longint expll;
    logic [16*W-1:0] eb;
    logic [8*W-1:0] h;
    for (int b = 0; b < nblk; b++) begin
      cyc = 0;
      while (!core_valid_o && cyc < 3000) begin
        @(negedge clk);
        cyc++;
      end
      check("issue_seen", 512'(core_valid_o), 1);
      expll = (msg.size() < 128*(b+1)) ? longint'(msg.size()) : longint'(128*(b+1));
      eb = exp_block(b);
      check("first", 512'(core_first_o), 512'(b == 0));
      check("last", 512'(core_last_o), 512'(b == nblk - 1));
      check("ll", 512'(core_ll_o), 512'(expll));
      check("kk", 512'(core_kk_o), 512'(msg_kk));
      check("nn", 512'(core_nn_o), 512'd64);
      check("blk_lo", core_d_o[511:0], eb[511:0]);
      check("blk_hi", core_d_o[1023:512], eb[1023:512]);
      check("ready_issue", 512'(data_ready_o), 0);
      @(negedge clk);
      check("pulse_one", 512'(core_valid_o), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("ready_wait", 512'(data_ready_o), 0);
      check("hold_ll", 512'(core_ll_o), 512'(expll));
      check("hold_blk", core_d_o[511:0], eb[511:0]);
      for (int j = 0; j < 8*W/32; j++) h[32*j +: 32] = $urandom;
      core_h_i    = h;
      core_done_i = 1'b1;
      @(negedge clk);
      core_done_i = 1'b0;
      check("ready_after_done", 512'(data_ready_o), 1);
      if (b == nblk - 1) begin
        check("hash_valid", 512'(hash_valid_o), 1);
        check("hash", hash_o, h);
        @(negedge clk);
        check("hash_pulse_one", 512'(hash_valid_o), 0);
      end else begin
        check("no_hash_mid", 512'(hash_valid_o), 0);
      end
    end
  endtask

  task automatic send_msg(input bit gaps);
    int nblk;
    int base;
    nblk = (num_words() + 15) / 16;
    base = issue_cnt;
    fork
      drive(gaps);
      respond(nblk);
    join
    repeat (3) @(negedge clk);
    check("issue_count", 512'(issue_cnt - base), 512'(nblk));
  endtask

  task automatic rand_msg(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(byte'($urandom));
    msg_kk = 8'($urandom);
  endtask

  initial begin
    reset = 1'b1; kk_i = '0; data_valid_i = 1'b0; data_i = '0; data_last_i = 1'b0;
    data_bytes_i = '0; core_done_i = 1'b0; core_h_i = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 512'(data_ready_o), 0);
    check("rst_valid", 512'(core_valid_o), 0);
    check("rst_hvalid", 512'(hash_valid_o), 0);
    check("rst_hash", hash_o, 0);
    check("rst_blk", core_d_o[511:0], 0);
    check("rst_flags", 512'({core_first_o, core_last_o}), 0);
    check("rst_ll", 512'(core_ll_o), 0);
    check("rst_kk", 512'(core_kk_o), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 512'(data_ready_o), 1);

    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    msg_kk = 8'h00;
    send_msg(1'b0);

    rand_msg(128); send_msg(1'b0);
    rand_msg(133); send_msg(1'b0);
    rand_msg(0);   send_msg(1'b0);
    rand_msg(256); send_msg(1'b1);

    for (int t = 0; t < 12; t++) begin
      rand_msg($urandom_range(0, 400));
      send_msg(t[0]);
    end

    // reset while the core is busy; a late done must be ignored
    @(negedge clk);
    data_valid_i = 1'b1; data_i = 64'h1122334455667788; data_last_i = 1'b1;
    data_bytes_i = BW'(5); kk_i = 8'h21;
    @(negedge clk);
    data_valid_i = 1'b0;
    check("rw_issue", 512'(core_valid_o), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    core_done_i = 1'b1;
    core_h_i = {16{32'hdeadbeef}};
    @(negedge clk);
    core_done_i = 1'b0;
    check("rw_ready", 512'(data_ready_o), 1);
    check("rw_no_hash", 512'(hash_valid_o), 0);
    check("rw_ll", 512'(core_ll_o), 0);
    @(negedge clk);
    check("rw_no_hash2", 512'(hash_valid_o), 0);
    rand_msg(140); send_msg(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blake2_block_ctrl.md
# blake2_block_ctrl

Message sequencer in front of the blake2 compression core. It accepts a message as a stream of W-bit words and packs them into 16-word blocks. It zero-pads the final block, tracks the running byte count, and issues each block to the core with correct first/last flags and length. It then waits for the core to finish, and presents the resulting hash with a one-cycle valid pulse.

## Interface
Parameters:
- W, 64, word width in bits (64 = blake2b, 32 = blake2s)
- NN, 8'd64, digest length in bytes, driven on core_nn_o

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- kk_i  in  8  key length, sampled with first accepted word
- data_valid_i  in  1  input word valid
- data_ready_o  out  1  controller can accept a word
- data_i  in  W  message word, byte k at bits [8k+7:8k]
- data_last_i  in  1  word is the last of the message
- data_bytes_i  in  $clog2(W/8)+1  valid bytes in the last word, 0..W/8; 0 legal only for a single-word (empty) message
- core_valid_o  out  1  one-cycle block issue strobe to the core
- core_d_o  out  16*W  block, word i at bits [W*i+W-1:W*i]
- core_first_o  out  1  block is the first of the message
- core_last_o  out  1  block is the final block
- core_ll_o  out  64  total message bytes through the end of this block
- core_kk_o  out  8  latched kk_i
- core_nn_o  out  8  NN
- core_done_i  in  1  core valid_o, one-cycle pulse, block compressed
- core_h_i  in  8*W  core hash output, valid with core_done_i
- hash_valid_o  out  1  one-cycle pulse, digest ready
- hash_o  out  8*W  registered digest

## Operation
FSM states: IDLE, FILL, ISSUE, WAIT.
- **IDLE:** data_ready_o=1.
  - An accepted word sets first_q=1, latches kk_i, clears ll_q, and writes buffer word 0.
  - If the word is last, go to ISSUE. Otherwise set word_idx=1 and go to FILL.
- **FILL:** data_ready_o=1.
  - Each accepted word is written at word_idx, then word_idx increments.
  - Go to ISSUE when the accepted word is last, or when word_idx==15 at acceptance (16th word).
- **ISSUE:** data_ready_o=0.
  - core_valid_o=1 for exactly this one cycle.
  - core_first_o=first_q, core_last_o=last_q, core_ll_o=ll_q.
  - Next state is WAIT.
- **WAIT:** data_ready_o=0.
  - On core_done_i with last_q=1: capture core_h_i into hash_o, pulse hash_valid_o next cycle, go to IDLE.
  - On core_done_i with last_q=0: clear first_q, set word_idx=0, clear the buffer, go to FILL.
- **Padding:** on the last word, bytes at index ≥ data_bytes_i are forced to zero. Buffer words after the last word stay zero; the buffer is cleared on entry to FILL and IDLE.
- **Byte count:** ll_q += W/8 per non-last word, += data_bytes_i on the last word. 64-bit, wraps mod 2^64.
- **Exact multiple of 16 words:** the block containing the last word is the final block. No extra empty block is issued.
- **Empty message:** one word with data_last_i=1 and data_bytes_i=0 issues a single all-zero block with first=last=1 and ll=0.
- core_done_i outside WAIT is ignored.
- The core_* outputs are held stable from ISSUE until core_done_i.

## Timing
- **Reset values:**
  - outputs: data_ready_o=0 during reset and 1 the cycle after (IDLE); core_valid_o=0, hash_valid_o=0, hash_o=0, core_d_o=0, core_first_o=0, core_last_o=0, core_ll_o=0, core_kk_o=0.
  - internal: state=IDLE, word_idx=0.
- Reset mid-message (any state) returns to IDLE next cycle and discards the buffer and counters. A core_done_i arriving later is ignored.
- A word is accepted on data_valid_i & data_ready_o. data_ready_o is a decode of the registered state only.
- The 16th or last word is accepted in cycle N; core_valid_o is high in cycle N+1.
- core_done_i at cycle M:
  - next block: data_ready_o=1 at M+1.
  - final block: hash_valid_o=1 and hash_o valid at M+1, IDLE with data_ready_o=1 at M+1.
- Max throughput: 16 words, then 1 issue cycle, then the core latency plus 1 cycle.

## Test plan
- **Single word:** "abc" (data_i=0x636261, data_bytes_i=3, last) → one core_valid_o pulse with first=last=1, ll=3, word0=0x0000000000636261, words 1..15 = 0.
- **Exactly 16 full words:** → one block with first=last=1, ll=128, no second issue; the hash_valid_o pulse follows core_done_i by 1 cycle.
- **17 words, last with 5 bytes:**
  - block 1: first=1, last=0, ll=128.
  - block 2: first=0, last=1, ll=133; word0 has upper 3 bytes zeroed.
- **Empty message** (data_bytes_i=0, last): → block all zero, ll=0, first=last=1.
- **Backpressure:** data_valid_i held high across ISSUE/WAIT → no word accepted until core_done_i+1. Spurious core_done_i in FILL has no effect.
- **Reset during WAIT, then late core_done_i:** → no hash_valid_o. A new message restarts with first=1 and ll counted from 0.
